// File: rtl/sc_io_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : sc_io_responder_if
//  Description : Single-cycle CPU data-bus bundle between the load/store
//                initiator (master) and the memory-mapped I/O responder
//                (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface sc_io_responder_if;
  logic        we;       // store strobe
  logic [31:0] addr;     // byte address
  logic [31:0] datain;   // store data
  logic        io_sel;   // address falls in the I/O window
  logic [31:0] dataout;  // combinational read data

  modport master (output we, addr, datain, input  io_sel, dataout);
  modport slave  (input  we, addr, datain, output io_sel, dataout);
endinterface
`default_nettype wire

// File: rtl/sc_io_responder.sv
`default_nettype none
// ============================================================================
//  Module      : sc_io_responder
//  Description : Memory-mapped I/O responder for the single-cycle CPU bus.
//                Three output registers, two synchronised input ports with
//                write-1-to-clear change flags, and a reloading down-counter.
//                Optional input debouncer enabled by defining IO_DEBOUNCE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module sc_io_responder #(
  parameter int IO_BIT          = 7,
  parameter int SYNC_STAGES     = 2,
  parameter int TIMER_W         = 32,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                     clock,
  input  logic                     resetn,
  sc_io_responder_if.slave         bus,
  input  logic [31:0]              in_port0,
  input  logic [31:0]              in_port1,
  output logic [31:0]              out_port0,
  output logic [31:0]              out_port1,
  output logic [31:0]              out_port2
);

  localparam logic [3:0] ADR_OUT0   = 4'h0;
  localparam logic [3:0] ADR_OUT1   = 4'h1;
  localparam logic [3:0] ADR_OUT2   = 4'h2;
  localparam logic [3:0] ADR_IN0    = 4'h3;
  localparam logic [3:0] ADR_IN1    = 4'h4;
  localparam logic [3:0] ADR_STATUS = 4'h5;
  localparam logic [3:0] ADR_TLOAD  = 4'h6;
  localparam logic [3:0] ADR_TCOUNT = 4'h7;

  // Reject configurations the datapath cannot represent.
  if (SYNC_STAGES < 2 || TIMER_W < 1 || TIMER_W > 32 ||
      DEBOUNCE_CYCLES < 1 || IO_BIT > 31) begin : g_param_check
    $error("sc_io_responder: parameter out of range");
  end

  logic              io_sel;
  logic              wr_en;
  logic [3:0]        reg_idx;
  logic [31:0]       rd_data;
  logic [31:0]       pin      [2];
  logic [31:0]       sync_q   [2][SYNC_STAGES];
  logic [31:0]       in_val   [2];
  logic [1:0]        chg_set;
  logic [2:0]        status_q, status_d;
  logic [2:0]        w1c_mask;
  logic [TIMER_W-1:0] tload_q, tload_d;
  logic [TIMER_W-1:0] tcount_q, tcount_d;
  logic              tmr_exp;
  logic [31:0]       tload_ext, tcount_ext;
  logic              unused_addr_bits;

  assign io_sel      = bus.addr[IO_BIT];
  assign bus.io_sel  = io_sel;
  assign wr_en       = bus.we & io_sel;
  assign reg_idx     = bus.addr[5:2];
  assign pin[0]      = in_port0;
  assign pin[1]      = in_port1;
  // Only the window bit and the word index are decoded.
  assign unused_addr_bits = ^bus.addr;

  // Two-flop (or deeper) synchroniser chain per input port.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int c = 0; c < 2; c++)
        for (int s = 0; s < SYNC_STAGES; s++)
          sync_q[c][s] <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        sync_q[c][0] <= pin[c];
        for (int s = 1; s < SYNC_STAGES; s++)
          sync_q[c][s] <= sync_q[c][s-1];
      end
    end
  end

`ifdef IO_DEBOUNCE_EN
  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
`endif

  for (genvar c = 0; c < 2; c++) begin : g_chan
`ifdef IO_DEBOUNCE_EN
    logic [31:0]      cand_q;
    logic [31:0]      deb_q;
    logic [CNT_W-1:0] cnt_q;

    // Accept the candidate once it has been sampled unchanged long enough.
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        cand_q <= '0;
        deb_q  <= '0;
        cnt_q  <= '0;
      end else begin
        if (cnt_q == CNT_MAX && cand_q != deb_q)
          deb_q <= cand_q;
        if (sync_q[c][SYNC_STAGES-1] != cand_q) begin
          cand_q <= sync_q[c][SYNC_STAGES-1];
          cnt_q  <= CNT_W'(1);
        end else if (cnt_q != CNT_MAX) begin
          cnt_q  <= cnt_q + CNT_W'(1);
        end
      end
    end

    assign in_val[c]  = deb_q;
    assign chg_set[c] = (cnt_q == CNT_MAX) && (cand_q != deb_q);
`else
    // Flag fires on the same edge the final stage takes a new value.
    assign in_val[c]  = sync_q[c][SYNC_STAGES-1];
    assign chg_set[c] = sync_q[c][SYNC_STAGES-2] != sync_q[c][SYNC_STAGES-1];
`endif
  end

  assign tmr_exp = (tload_q != '0) && (tcount_q == TIMER_W'(1));

  // Timer next state: a TLOAD write overrides the count; expiry still flags.
  always_comb begin
    tload_d  = tload_q;
    tcount_d = tcount_q;
    if (wr_en && reg_idx == ADR_TLOAD) begin
      tload_d  = bus.datain[TIMER_W-1:0];
      tcount_d = bus.datain[TIMER_W-1:0];
    end else if (tload_q != '0) begin
      if (tmr_exp)
        tcount_d = tload_q;
      else if (tcount_q != '0)
        tcount_d = tcount_q - TIMER_W'(1);
    end
  end

  // Status next state: set conditions beat a simultaneous write-1-to-clear.
  always_comb begin
    w1c_mask = (wr_en && reg_idx == ADR_STATUS) ? bus.datain[2:0] : 3'b000;
    status_d = (status_q & ~w1c_mask) | {tmr_exp, chg_set};
  end

  // Register update for outputs, timer and status.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_port0 <= '0;
      out_port1 <= '0;
      out_port2 <= '0;
      tload_q   <= '0;
      tcount_q  <= '0;
      status_q  <= '0;
    end else begin
      if (wr_en && reg_idx == ADR_OUT0) out_port0 <= bus.datain;
      if (wr_en && reg_idx == ADR_OUT1) out_port1 <= bus.datain;
      if (wr_en && reg_idx == ADR_OUT2) out_port2 <= bus.datain;
      tload_q  <= tload_d;
      tcount_q <= tcount_d;
      status_q <= status_d;
    end
  end

  // Zero-extend timer registers to the bus width.
  always_comb begin
    tload_ext                 = '0;
    tcount_ext                = '0;
    tload_ext[TIMER_W-1:0]    = tload_q;
    tcount_ext[TIMER_W-1:0]   = tcount_q;
  end

  // Zero-wait-state read mux; unmapped words and non-I/O addresses read 0.
  always_comb begin
    rd_data = '0;
    case (reg_idx)
      ADR_OUT0:   rd_data = out_port0;
      ADR_OUT1:   rd_data = out_port1;
      ADR_OUT2:   rd_data = out_port2;
      ADR_IN0:    rd_data = in_val[0];
      ADR_IN1:    rd_data = in_val[1];
      ADR_STATUS: rd_data = {29'b0, status_q};
      ADR_TLOAD:  rd_data = tload_ext;
      ADR_TCOUNT: rd_data = tcount_ext;
      default:    rd_data = '0;
    endcase
    bus.dataout = io_sel ? rd_data : 32'h0;
  end

endmodule
`default_nettype wire

// File: tb/tb_sc_io_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sc_io_responder
//  Description : Self-checking bench for sc_io_responder: directed scenarios
//                plus randomized bus/input traffic against a reference model.
//                Honors IO_DEBOUNCE_EN when defined for the build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_io_responder;
  localparam int IO_BIT          = 7;
  localparam int SYNC_STAGES     = 2;
  localparam int TIMER_W         = 32;
  localparam int DEBOUNCE_CYCLES = 16;
  localparam logic [31:0] TMASK  = 32'hFFFF_FFFF >> (32 - TIMER_W);

  logic        clock  = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] in_port0 = '0;
  logic [31:0] in_port1 = '0;
  logic [31:0] out_port0, out_port1, out_port2;

  sc_io_responder_if bus_if();

  sc_io_responder #(
    .IO_BIT(IO_BIT), .SYNC_STAGES(SYNC_STAGES),
    .TIMER_W(TIMER_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .clock(clock), .resetn(resetn), .bus(bus_if),
    .in_port0(in_port0), .in_port1(in_port1),
    .out_port0(out_port0), .out_port1(out_port1), .out_port2(out_port2)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_out  [3];
  logic [31:0] m_in   [2];
  logic [31:0] m_pipe0[$];
  logic [31:0] m_pipe1[$];
  logic [31:0] m_last [2];
  int          m_run  [2];
  logic [2:0]  m_stat;
  logic [31:0] m_tload, m_tcnt;

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) m_out[i] = '0;
    for (int c = 0; c < 2; c++) begin m_in[c] = '0; m_last[c] = '0; m_run[c] = 0; end
    m_pipe0.delete(); m_pipe1.delete();
    for (int s = 0; s < SYNC_STAGES; s++) begin m_pipe0.push_front('0); m_pipe1.push_front('0); end
    m_stat = '0; m_tload = '0; m_tcnt = '0;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (!a[IO_BIT]) return 32'h0;
    case (a[5:2])
      4'd0: return m_out[0];
      4'd1: return m_out[1];
      4'd2: return m_out[2];
      4'd3: return m_in[0];
      4'd4: return m_in[1];
      4'd5: return {29'b0, m_stat};
      4'd6: return m_tload;
      4'd7: return m_tcnt;
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_edge(input logic we, input logic [31:0] a, input logic [31:0] d);
    logic        wr;
    int          idx;
    logic [31:0] old_raw [2];
    logic [31:0] new_raw [2];
    logic [2:0]  setv, clr;
    wr  = we && a[IO_BIT];
    idx = int'(a[5:2]);
    setv = '0;
    // expiry: the cycle the counter sits at 1 while the timer is running
    setv[2] = (m_tload != 0) && (m_tcnt == 1);
    old_raw[0] = m_pipe0.pop_back(); m_pipe0.push_front(in_port0); new_raw[0] = m_pipe0[$];
    old_raw[1] = m_pipe1.pop_back(); m_pipe1.push_front(in_port1); new_raw[1] = m_pipe1[$];
    for (int c = 0; c < 2; c++) begin
`ifdef IO_DEBOUNCE_EN
      if (m_run[c] >= DEBOUNCE_CYCLES && m_last[c] != m_in[c]) begin
        m_in[c] = m_last[c]; setv[c] = 1'b1;
      end
      if (old_raw[c] == m_last[c]) m_run[c]++;
      else begin m_last[c] = old_raw[c]; m_run[c] = 1; end
`else
      setv[c] = (new_raw[c] != m_in[c]);
      m_in[c] = new_raw[c];
`endif
    end
    if (wr && idx == 6) begin
      m_tload = d & TMASK; m_tcnt = d & TMASK;
    end else if (m_tload != 0) begin
      m_tcnt = (m_tcnt == 1) ? m_tload : m_tcnt - 1;
    end
    clr = (wr && idx == 5) ? d[2:0] : 3'b000;
    m_stat = (m_stat & ~clr) | setv;
    if (wr && idx < 3) m_out[idx] = d;
  endfunction

  // ---------------- stimulus helpers ----------------
  // One bus cycle: drive, check combinational read and ports mid-cycle, clock.
  task automatic do_cycle(input logic we, input logic [31:0] a, input logic [31:0] d);
    bus_if.we = we; bus_if.addr = a; bus_if.datain = d;
    @(negedge clock);
    check_eq("io_sel", {31'b0, bus_if.io_sel}, {31'b0, a[IO_BIT]});
    check_eq($sformatf("dataout@%08h", a), bus_if.dataout, model_rd(a));
    check_eq("out_port0", out_port0, m_out[0]);
    check_eq("out_port1", out_port1, m_out[1]);
    check_eq("out_port2", out_port2, m_out[2]);
    @(posedge clock);
    model_edge(we, a, d);
    #1;
  endtask

  // Combinational read right after an edge, against a fixed expectation.
  task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus_if.we = 1'b0; bus_if.addr = a; bus_if.datain = '0;
    #1;
    check_eq(tag, bus_if.dataout, exp);
  endtask

  task automatic release_reset();
    bus_if.we = 1'b0; bus_if.addr = '0; bus_if.datain = '0;
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    model_edge(1'b0, 32'h0, 32'h0);
    #1;
  endtask

  task automatic async_reset();
    #2 resetn = 1'b0;
    #1;
    check_eq("rst_out_port0", out_port0, 32'h0);
    check_eq("rst_out_port1", out_port1, 32'h0);
    check_eq("rst_out_port2", out_port2, 32'h0);
    peek("rst_status", 32'h94, 32'h0);
    peek("rst_tcount", 32'h9C, 32'h0);
    model_reset();
    release_reset();
  endtask

  initial begin
    bus_if.we = 1'b0; bus_if.addr = '0; bus_if.datain = '0;
    model_reset();
    #1;
    check_eq("init_out_port0", out_port0, 32'h0);
    peek("init_status", 32'h94, 32'h0);
    release_reset();

    // 1: asynchronous reset mid-run
    do_cycle(1'b1, 32'h80, 32'h1234);
    check_eq("out0_written", out_port0, 32'h1234);
    do_cycle(1'b1, 32'h98, 32'd9);
    peek("tcount_loaded", 32'h9C, 32'd9);
    async_reset();

    // 2: output register write/read, non-I/O store ignored
    do_cycle(1'b1, 32'h84, 32'hDEADBEEF);
    check_eq("out_port1_wr", out_port1, 32'hDEADBEEF);
    peek("rd_out1", 32'h84, 32'hDEADBEEF);
    do_cycle(1'b1, 32'h04, 32'h1111_1111);
    check_eq("nonio_out0", out_port0, 32'h0);
    check_eq("nonio_out1", out_port1, 32'hDEADBEEF);
    check_eq("nonio_out2", out_port2, 32'h0);
    do_cycle(1'b0, 32'h04, 32'h0);

    // 3: input synchronisation, change flag, W1C and set-wins
    in_port0 = 32'h5A;
    do_cycle(1'b0, 32'h8C, 32'h0);
    do_cycle(1'b0, 32'h8C, 32'h0);
`ifndef IO_DEBOUNCE_EN
    peek("in0_sync", 32'h8C, 32'h5A);
    peek("status_chg0", 32'h94, 32'h1);
`endif
    do_cycle(1'b1, 32'h94, 32'h1);
`ifndef IO_DEBOUNCE_EN
    peek("status_w1c", 32'h94, 32'h0);
`endif
    in_port0 = 32'hA5;
    do_cycle(1'b0, 32'h8C, 32'h0);
    do_cycle(1'b1, 32'h94, 32'h1);
`ifndef IO_DEBOUNCE_EN
    peek("status_set_wins", 32'h94, 32'h1);
`endif
    for (int i = 0; i < 30; i++) do_cycle(1'b0, 32'h8C, 32'h0);

    // 4: timer period, coincident clear/load at expiry, freeze
    do_cycle(1'b1, 32'h94, 32'h7);
    do_cycle(1'b1, 32'h98, 32'd4);
    for (int i = 0; i < 12; i++) begin
      peek("tcount_seq", 32'h9C, 32'(4 - (i % 4)));
      do_cycle(1'b0, 32'h9C, 32'h0);
    end
    peek("status_tmr", 32'h94, 32'h4);
    do_cycle(1'b1, 32'h98, 32'd2);
    do_cycle(1'b1, 32'h94, 32'h7);      // count 2 -> 1, flag cleared
    peek("tmr_clr", 32'h94, 32'h0);
    do_cycle(1'b1, 32'h94, 32'h7);      // expiry edge with W1C
    peek("tmr_set_wins", 32'h94, 32'h4);
    peek("tmr_reload", 32'h9C, 32'd2);
    do_cycle(1'b1, 32'h94, 32'h7);      // count 2 -> 1
    do_cycle(1'b1, 32'h98, 32'd6);      // TLOAD write at expiry
    peek("tload_at_exp_cnt", 32'h9C, 32'd6);
    peek("tload_at_exp_flag", 32'h94, 32'h4);
    do_cycle(1'b1, 32'h98, 32'd0);
    for (int i = 0; i < 3; i++) begin
      peek("tcount_frozen", 32'h9C, 32'h0);
      do_cycle(1'b0, 32'h9C, 32'h0);
    end

    // 5: unmapped words read 0 and ignore writes
    for (int k = 8; k < 16; k++) begin
      do_cycle(1'b1, 32'h80 | (k << 2), $urandom());
      peek("unmapped", 32'h80 | (k << 2), 32'h0);
    end

`ifdef IO_DEBOUNCE_EN
    // 6: bouncing input rejected, stable input accepted
    do_cycle(1'b1, 32'h94, 32'h7);
    for (int i = 0; i < 40; i++) begin
      if (i % 5 == 0) in_port1 = in_port1 ^ 32'h1;
      do_cycle(1'b0, 32'h90, 32'h0);
    end
    peek("deb_in1_bounce", 32'h90, 32'h0);
    peek("deb_stat_bounce", 32'h94, 32'h0);
    in_port1 = 32'h1;
    for (int i = 0; i < 25; i++) do_cycle(1'b0, 32'h90, 32'h0);
    peek("deb_in1_stable", 32'h90, 32'h1);
    peek("deb_stat_stable", 32'h94, 32'h2);
`endif

    // Randomized traffic checked against the model every cycle
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a, d;
      logic        we;
      a = $urandom();
      a[IO_BIT] = ($urandom_range(0, 3) != 0);
      d = $urandom();
      if (a[5:2] == 4'd6) d = $urandom_range(0, 9);
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) in_port0 = $urandom();
      if ($urandom_range(0, 15) == 0) in_port1 = $urandom();
      do_cycle(we, a, d);
      if (i == 300) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sc_io_responder.md
Name: sc_io_responder

Overview:
- Memory-mapped I/O responder on the single-cycle CPU data bus. It is the target-side counterpart to the CPU's load/store initiator.
- Decodes the I/O address window and holds three output port registers.
- Synchronises two input ports, flags input changes in a write-1-to-clear status register, and provides a reloading down-count timer.
- Sits beside the data RAM. The data-memory wrapper muxes its dataout using io_sel.

Parameters:
- IO_BIT, 7, address bit that selects the I/O window (addr[IO_BIT]=1 means I/O).
- SYNC_STAGES, 2, flop stages on each input port, minimum 2.
- TIMER_W, 32, width of the timer load and counter registers, 1..32.
- DEBOUNCE_CYCLES, 16, stable-cycle count used only when IO_DEBOUNCE_EN is defined.

Ports:
- clock  in  1  single system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- we  in  1  CPU store strobe.
- addr  in  32  CPU byte address (aluout).
- datain  in  32  CPU store data.
- in_port0  in  32  external input, asynchronous to clock.
- in_port1  in  32  external input, asynchronous to clock.
- io_sel  out  1  combinational; addr[IO_BIT].
- dataout  out  32  combinational read data; 0 when io_sel=0.
- out_port0  out  32  output register 0.
- out_port1  out  32  output register 1.
- out_port2  out  32  output register 2.

Behaviour:
- Register map, decoded on addr[5:2] with addr[1:0] ignored and addr[IO_BIT]=1:
  - 0x0 OUT0 R/W.
  - 0x1 OUT1 R/W.
  - 0x2 OUT2 R/W.
  - 0x3 IN0 RO.
  - 0x4 IN1 RO.
  - 0x5 STATUS: bit0 in0_chg, bit1 in1_chg, bit2 tmr_exp; write-1-to-clear; bits 31:3 read 0.
  - 0x6 TLOAD R/W, low TIMER_W bits.
  - 0x7 TCOUNT RO.
  - 0x8..0xF read 0; writes to them are ignored.
- Writes: take effect on the rising clock edge when we=1 and io_sel=1. When io_sel=0, a write has no effect on any register.
- Reads: dataout is combinational from current register values, with zero wait states, matching the single-cycle CPU.
- Reset: all outputs and registers go to 0, including out_port0..2, sync chains, STATUS, TLOAD and TCOUNT.
- Input sync: in_portN passes through a SYNC_STAGES flop chain. IN0/IN1 return the final stage, so latency from pin to readable value is SYNC_STAGES cycles.
- Change detect: inN_chg sets on the cycle the final sync stage differs from its previous value.
- Timer:
  - A TLOAD write loads TCOUNT with datain in the same edge.
  - If TLOAD=0, the timer is idle and TCOUNT holds.
  - Otherwise TCOUNT decrements by 1 each cycle.
  - On the edge where TCOUNT=1, TCOUNT reloads from TLOAD and tmr_exp sets. The period is TLOAD cycles.
- Simultaneous events:
  - A set condition and a W1C of the same bit in one cycle leave the bit set (set wins).
  - A TLOAD write coincident with expiry loads the new value and still sets tmr_exp.
- Reset mid-operation: async clear wins immediately; no partial writes survive.
- Arithmetic: TCOUNT is unsigned, never underflows, and is zero-extended on read.

Optional Feature:
- IO_DEBOUNCE_EN defined:
  - Each synchronised input feeds a debouncer. The debouncer holds a candidate value and a counter of width clog2(DEBOUNCE_CYCLES+1).
  - IN0/IN1 update, and inN_chg sets, only after the synchronised value stays identical for DEBOUNCE_CYCLES consecutive cycles.
  - Any differing sample restarts the count.
- Undefined: no debouncer. IN0/IN1 are the raw sync outputs and change detect is as above.

Test Plan:
1. Reset with resetn=0 mid-run after out_port0=0x1234 -> out_port0..2, dataout at 0x94 (STATUS), and TCOUNT read 0 without waiting for a clock edge.
2. Store 0xDEADBEEF to 0x84, then load 0x84 -> out_port1=0xDEADBEEF after the edge and dataout=0xDEADBEEF. A store to 0x04 (io_sel=0) leaves all ports unchanged.
3. in_port0 steps 0→0x5A with SYNC_STAGES=2 -> IN0 reads 0x5A two edges later and STATUS=0x1. Write 0x1 to 0x94 -> STATUS=0x0. A W1C coinciding with a new change leaves bit0=1.
4. Write TLOAD=4 -> TCOUNT reads 4,3,2,1,4,… and tmr_exp sets every 4 cycles. Writing TLOAD=0 freezes TCOUNT.
5. Read 0xA0..0xBC -> dataout=0. Writes there change nothing.
6. With IO_DEBOUNCE_EN and DEBOUNCE_CYCLES=16, toggle in_port1 bit0 every 5 cycles -> IN1 and in1_chg stay 0. Hold it for 20 cycles -> IN1=0x1 and STATUS bit1=1.
